reg64_rr_arbiter: RTL

//  Shares one 64-bit storage register between NREQ writers using round-robin arbitration.

---
 rtl/reg64_rr_arbiter.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/reg64_rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | reg64_rr_arbiter                                                           |
// | Round-robin arbitrated 64-bit shared register with lockable ownership.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module reg64_rr_arbiter #(
   parameter int NREQ     = 4,
   parameter int DW       = 64,
   parameter int LOCK_MAX = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [NREQ-1:0]      req_valid,
   input  logic [NREQ*DW-1:0]   req_data,
   input  logic [NREQ-1:0]      req_lock,
   output logic [NREQ-1:0]      req_ready,
   output logic [2:0]           gnt_id,
   output logic                 busy,
   output logic [DW-1:0]        data_q,
   output logic                 wr_pulse,
   output logic                 lock_tmo
);

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_GRANT   = 2'd1;
   localparam logic [1:0] S_HOLD    = 2'd2;
   localparam logic [7:0] HOLD_LAST = 8'(LOCK_MAX - 1);

   logic [1:0]      state_q,     state_d;
   logic [2:0]      gnt_id_q,    gnt_id_d;
   logic [2:0]      ptr_q,       ptr_d;
   logic [7:0]      hold_cnt_q,  hold_cnt_d;
   logic [NREQ-1:0] req_ready_q, req_ready_d;
   logic [DW-1:0]   data_d;
   logic            wr_pulse_q,  wr_pulse_d;
   logic            lock_tmo_q,  lock_tmo_d;

   logic            any_valid;
   logic [2:0]      winner;
   logic [2:0]      ptr_next;
   logic            own_valid;
   logic            own_lock;
   logic [DW-1:0]   own_data;

   // Walk requesters in priority order ptr, ptr+1, ... and keep the first valid one.
   always_comb begin
      any_valid = 1'b0;
      winner    = ptr_q;
      for (int k = 0; k < NREQ; k++) begin
         for (int j = 0; j < NREQ; j++) begin
            if (!any_valid && req_valid[j] && ((int'(ptr_q) + k) % NREQ) == j) begin
               any_valid = 1'b1;
               winner    = 3'(j);
            end
         end
      end
   end

   always_comb begin
      own_valid = 1'b0;
      own_lock  = 1'b0;
      own_data  = '0;
      for (int j = 0; j < NREQ; j++) begin
         if (gnt_id_q == 3'(j)) begin
            own_valid = req_valid[j];
            own_lock  = req_lock[j];
            own_data  = req_data[j*DW +: DW];
         end
      end
   end

   assign ptr_next = (gnt_id_q == 3'(NREQ - 1)) ? 3'd0 : gnt_id_q + 3'd1;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= S_IDLE;
         gnt_id_q    <= 3'd0;
         ptr_q       <= 3'd0;
         hold_cnt_q  <= 8'd0;
         req_ready_q <= '0;
         data_q      <= '0;
         wr_pulse_q  <= 1'b0;
         lock_tmo_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         gnt_id_q    <= gnt_id_d;
         ptr_q       <= ptr_d;
         hold_cnt_q  <= hold_cnt_d;
         req_ready_q <= req_ready_d;
         data_q      <= data_d;
         wr_pulse_q  <= wr_pulse_d;
         lock_tmo_q  <= lock_tmo_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (any_valid) state_d = S_GRANT;
         S_GRANT: state_d = (own_valid && own_lock) ? S_HOLD : S_IDLE;
         S_HOLD:  if (!own_lock || hold_cnt_q == HOLD_LAST) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      gnt_id_d   = gnt_id_q;
      ptr_d      = ptr_q;
      hold_cnt_d = hold_cnt_q;
      data_d     = data_q;
      wr_pulse_d = 1'b0;
      lock_tmo_d = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (any_valid) gnt_id_d = winner;
         end
         S_GRANT: begin
            hold_cnt_d = 8'd0;
            if (own_valid) begin
               data_d     = own_data;
               wr_pulse_d = 1'b1;
            end
            if (!(own_valid && own_lock)) ptr_d = ptr_next;
         end
         S_HOLD: begin
            hold_cnt_d = hold_cnt_q + 8'd1;
            if (own_valid) begin
               data_d     = own_data;
               wr_pulse_d = 1'b1;
            end
            if (!own_lock) begin
               ptr_d = ptr_next;
            end else if (hold_cnt_q == HOLD_LAST) begin
               ptr_d      = ptr_next;
               lock_tmo_d = 1'b1;
            end
         end
         default: ;
      endcase
      // Ready is registered so it is already high on the first cycle of GRANT.
      for (int j = 0; j < NREQ; j++) begin
         req_ready_d[j] = (state_d != S_IDLE) && (gnt_id_d == 3'(j));
      end
   end

   assign req_ready = req_ready_q;
   assign gnt_id    = gnt_id_q;
   assign busy      = (state_q != S_IDLE);
   assign wr_pulse  = wr_pulse_q;
   assign lock_tmo  = lock_tmo_q;

endmodule
`default_nettype wire
